// File: rtl/ps2_player_inputs.sv
// ============================================================================
// Module   : ps2_player_inputs
// Purpose  : PS/2 keyboard receiver plus scan-code decoder that maintains
//            held-key vectors for two players.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_player_inputs #(
  parameter int TIMEOUT_CYCLES = 50_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [6:0] p1_inputs,
  output logic [6:0] p2_inputs,
  output logic       byte_valid,
  output logic       byte_err,
  output logic [7:0] scan_byte
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   ps2_fall;
  logic                   ps2_bit;

  rx_state_t              state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   parity_ok;
  logic [TW-1:0]          timeout_cnt;

  logic                   ext_pending;
  logic                   break_pending;
  logic [6:0]             p1_mask;
  logic [6:0]             p2_mask;

  // Bring the raw PS/2 lines into the clk domain; idle-high lines reset to 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign ps2_fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign ps2_bit  = data_sync[SYNC_STAGES-1];

  // Frame receiver: start/data/parity/stop sampled on PS/2 falling edges,
  // with a watchdog that abandons a frame whose clock stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      parity_ok   <= 1'b0;
      timeout_cnt <= '0;
      byte_valid  <= 1'b0;
      byte_err    <= 1'b0;
      scan_byte   <= 8'h00;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      if (ps2_fall) begin
        timeout_cnt <= '0;
        case (state)
          IDLE: begin
            if (!ps2_bit) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end else begin
              byte_err <= 1'b1;
            end
          end
          DATA: begin
            shift   <= {ps2_bit, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            // Odd parity across data plus parity bit
            parity_ok <= ^{shift, ps2_bit};
            state     <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (ps2_bit && parity_ok) begin
              byte_valid <= 1'b1;
              scan_byte  <= shift;
            end else begin
              byte_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (timeout_cnt == TIMEOUT_LAST) begin
          state       <= IDLE;
          bit_cnt     <= 3'd0;
          timeout_cnt <= '0;
          byte_err    <= 1'b1;
        end else begin
          timeout_cnt <= timeout_cnt + 1'b1;
        end
      end
    end
  end

  // Key map: (extended flag, code) -> one-hot bit in the player-1 or player-2 vector
  always_comb begin
    p1_mask = 7'b0;
    p2_mask = 7'b0;
    case ({ext_pending, scan_byte})
      9'h024: p1_mask = 7'b0000001;
      9'h01C: p1_mask = 7'b0000010;
      9'h023: p1_mask = 7'b0000100;
      9'h01D: p1_mask = 7'b0001000;
      9'h01B: p1_mask = 7'b0010000;
      9'h02B: p1_mask = 7'b0100000;
      9'h034: p1_mask = 7'b1000000;
      9'h03B: p2_mask = 7'b0000001;
      9'h16B: p2_mask = 7'b0000010;
      9'h174: p2_mask = 7'b0000100;
      9'h175: p2_mask = 7'b0001000;
      9'h172: p2_mask = 7'b0010000;
      9'h042: p2_mask = 7'b0100000;
      9'h04B: p2_mask = 7'b1000000;
      default: begin
        p1_mask = 7'b0;
        p2_mask = 7'b0;
      end
    endcase
  end

  // Decoder: prefixes arm the flags, code bytes make/break keys and clear them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_pending   <= 1'b0;
      break_pending <= 1'b0;
      p1_inputs     <= 7'b0;
      p2_inputs     <= 7'b0;
    end else if (byte_valid) begin
      if (scan_byte == 8'hE0) begin
        ext_pending <= 1'b1;
      end else if (scan_byte == 8'hF0) begin
        break_pending <= 1'b1;
      end else begin
        if (break_pending) begin
          p1_inputs <= p1_inputs & ~p1_mask;
          p2_inputs <= p2_inputs & ~p2_mask;
        end else begin
          p1_inputs <= p1_inputs | p1_mask;
          p2_inputs <= p2_inputs | p2_mask;
        end
        ext_pending   <= 1'b0;
        break_pending <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_player_inputs.sv
// ============================================================================
// Module   : tb_ps2_player_inputs
// Purpose  : Directed self-checking bench for ps2_player_inputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_player_inputs;

  localparam int TIMEOUT = 200;
  localparam int HALF    = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [6:0] p1_inputs;
  logic [6:0] p2_inputs;
  logic       byte_valid;
  logic       byte_err;
  logic [7:0] scan_byte;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int v0;
  int e0;

  ps2_player_inputs #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .SYNC_STAGES   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .p1_inputs (p1_inputs),
    .p2_inputs (p2_inputs),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .scan_byte (scan_byte)
  );

  always #5 clk = ~clk;

  // Pulse counters; a pulse wider than one cycle shows up as an extra count
  always @(posedge clk) begin
    if (byte_valid) valid_cnt <= valid_cnt + 1;
    if (byte_err)   err_cnt   <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic ps2_send_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    ps2_send_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_send_bit(d[i]);
    ps2_send_bit((~^d) ^ bad_par);
    ps2_send_bit(stop);
    ps2_data = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b1);
  endtask

  initial begin
    #1;
    check("rst_p1", 32'(p1_inputs), 32'h0);
    check("rst_p2", 32'(p2_inputs), 32'h0);
    check("rst_scan", 32'(scan_byte), 32'h0);
    check("rst_valid", 32'(byte_valid), 32'h0);
    check("rst_err", 32'(byte_err), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);

    // W make then break
    v0 = valid_cnt;
    send_byte(8'h1D);
    check("w_valid_pulse", 32'(valid_cnt - v0), 32'd1);
    check("w_scan", 32'(scan_byte), 32'h1D);
    check("w_make", 32'(p1_inputs), 32'b0001000);
    send_byte(8'hF0);
    send_byte(8'h1D);
    check("w_break", 32'(p1_inputs), 32'h0);

    // Extended P2 left make/break
    send_byte(8'hE0);
    send_byte(8'h6B);
    check("ext_make_p2", 32'(p2_inputs), 32'b0000010);
    check("ext_make_p1", 32'(p1_inputs), 32'h0);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    check("ext_break_p2", 32'(p2_inputs), 32'h0);
    check("ext_break_p1", 32'(p1_inputs), 32'h0);

    // Non-extended 0x6B is unmapped
    send_byte(8'h6B);
    check("plain_6b_p2", 32'(p2_inputs), 32'h0);

    // Bad parity
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h2B, 1'b1, 1'b1);
    check("par_err", 32'(err_cnt - e0), 32'd1);
    check("par_novalid", 32'(valid_cnt - v0), 32'd0);
    check("par_scan", 32'(scan_byte), 32'h6B);
    check("par_p1", 32'(p1_inputs), 32'h0);

    // Bad stop bit
    e0 = err_cnt;
    send_frame(8'h24, 1'b0, 1'b0);
    check("stop_err", 32'(err_cnt - e0), 32'd1);
    check("stop_p1", 32'(p1_inputs), 32'h0);

    // Timeout after five data bits, then a clean J-row frame
    e0 = err_cnt;
    ps2_send_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_send_bit(i[0]);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 60) @(posedge clk);
    @(negedge clk);
    check("tmo_err", 32'(err_cnt - e0), 32'd1);
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'h42);
    check("tmo_next_valid", 32'(valid_cnt - v0), 32'd1);
    check("tmo_next_err", 32'(err_cnt - e0), 32'd0);
    check("tmo_p2", 32'(p2_inputs), 32'b0100000);

    // Hold A and D, typematic repeats of A, release A
    send_byte(8'h1C);
    send_byte(8'h23);
    check("ad_held", 32'(p1_inputs), 32'b0000110);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h1C);
      check("a_repeat", 32'(p1_inputs), 32'b0000110);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("a_release", 32'(p1_inputs), 32'b0000100);

    // Unmapped code after F0 clears the break flag; next D is a make
    send_byte(8'hF0);
    send_byte(8'hAA);
    send_byte(8'h23);
    check("aa_clears_flag", 32'(p1_inputs), 32'b0000100);

    // Reset in the middle of a frame with keys held
    ps2_send_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_send_bit(1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_p1", 32'(p1_inputs), 32'h0);
    check("midrst_p2", 32'(p2_inputs), 32'h0);
    check("midrst_scan", 32'(scan_byte), 32'h0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'h34);
    check("postrst_valid", 32'(valid_cnt - v0), 32'd1);
    check("postrst_err", 32'(err_cnt - e0), 32'd0);
    check("postrst_p1", 32'(p1_inputs), 32'b1000000);
    check("postrst_scan", 32'(scan_byte), 32'h34);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_player_inputs.md
PS2_PLAYER_INPUTS -- requirements
Module: ps2_player_inputs

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50_000, clk cycles allowed between PS/2 falling edges inside a frame before the frame is aborted.
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth on ps2_clk and ps2_data (minimum 2).
REQ-003 clk  input  1  system clock (100 MHz); all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  raw PS/2 keyboard clock, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 keyboard data, asynchronous to clk.
REQ-007 p1_inputs  output  7  player-1 held-key vector: [0]center [1]left [2]right [3]up [4]down [5]attack [6]shield; 1 = held.
REQ-008 p2_inputs  output  7  player-2 held-key vector, same bit order as p1_inputs.
REQ-009 byte_valid  output  1  one-cycle pulse when a frame passes all checks.
REQ-010 byte_err  output  1  one-cycle pulse on parity, start, stop or timeout failure.
REQ-011 scan_byte  output  8  last valid received byte; held until the next valid byte.

Function
REQ-012 ps2_clk and ps2_data SHALL pass through SYNC_STAGES flip-flops; a falling edge SHALL be detected on the synchronised clock (previous 1, current 0); all sampling uses the synchronised data at that edge.
REQ-013 Receiver FSM states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: on falling edge with data 0 -> DATA with bit count 0; data 1 -> remain IDLE, assert byte_err.
REQ-015 DATA: each falling edge shifts data in LSB first; after the 8th bit -> PARITY.
REQ-016 PARITY: sample the parity bit -> STOP; a frame is valid only if the 8 data bits plus parity contain an odd number of ones.
REQ-017 STOP: sample the stop bit -> IDLE; stop 1 with good parity: byte_valid pulses the following cycle, scan_byte updates the same cycle; otherwise byte_err pulses and scan_byte is unchanged.
REQ-018 Timeout counter: clears on every falling edge, counts while FSM is not IDLE; on reaching TIMEOUT_CYCLES -> IDLE, byte_err pulses, partial byte discarded.
REQ-019 Decoder holds flags ext_pending and break_pending, both updated only on byte_valid.
REQ-020 Byte 0xE0 sets ext_pending; 0xF0 sets break_pending; other bytes are code bytes.
REQ-021 Code byte: look up (ext_pending, code); if mapped, set the bit when break_pending = 0, clear it when break_pending = 1; then clear both flags.
REQ-022 Unmapped code bytes (including 0xAA, 0xFA, 0xEE) SHALL change no output bit and SHALL clear both flags.
REQ-023 Map, non-extended: P1 0x24(E) center, 0x1C(A) left, 0x23(D) right, 0x1D(W) up, 0x1B(S) down, 0x2B(F) attack, 0x34(G) shield; P2 0x3B(J) center, 0x42(K) attack, 0x4B(L) shield.
REQ-024 Map, extended: P2 0x6B left, 0x74 right, 0x75 up, 0x72 down; extended codes not listed are unmapped; non-extended 0x6B/0x74/0x75/0x72 are unmapped.
REQ-025 Typematic repeat make codes for an already-held key SHALL leave that bit at 1.
REQ-026 p1_inputs/p2_inputs SHALL be registered and update the cycle after byte_valid; multiple bits may be 1 at once (opposing directions included; conflict resolution belongs to the consumer).
REQ-027 A byte_err SHALL leave ext_pending, break_pending and both input vectors unchanged.

Reset
REQ-028 While reset = 0: FSM IDLE, bit count 0, timeout 0, synchronisers 1, flags 0, p1_inputs = p2_inputs = 7'b0, scan_byte = 8'h00, byte_valid = byte_err = 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; the first falling edge after release is treated as a possible start bit.

Verification
REQ-030 Frame 0x1D (parity 1, stop 1) -> byte_valid one pulse, scan_byte = 8'h1D, p1_inputs = 7'b0001000; then F0,1D -> p1_inputs = 7'b0000000.
REQ-031 E0,6B then E0,F0,6B -> p2_inputs = 7'b0000010 after second byte, 7'b0000000 after the sequence; p1_inputs stays 0 throughout.
REQ-032 Frame 0x2B with parity bit 0 -> byte_err one pulse, no byte_valid, scan_byte and p1_inputs unchanged.
REQ-033 Five data bits then ps2_clk idle TIMEOUT_CYCLES -> byte_err, FSM IDLE; next complete 0x42 frame -> p2_inputs = 7'b0100000.
REQ-034 Hold A and D (1C,23), send 1C three times (repeat), then F0,1C -> p1_inputs 7'b0000110 during repeats, 7'b0000100 after release.
REQ-035 reset = 0 asserted after 4 data bits of a frame with keys held -> outputs zero immediately; after release a clean 0x34 frame -> p1_inputs = 7'b1000000.
